// File: rtl/dpram_pipe.sv
// True dual-port byte-enabled RAM with registered read data, valid strobes and write/write collision flag.
// Define DPRAM_PIPE_OREG_EN to add a second output register stage (read latency 2).
module dpram_pipe #(
    parameter int DATA     = 32,
    parameter int ADDR     = 4,
    parameter int BYTE     = 8,
    parameter int RDW_MODE = 0,
    localparam int NBE     = DATA / BYTE
) (
    input  logic            clK,
    input  logic            rst_N,
    input  logic            a_port_EN,
    input  logic            a_port_WR,
    input  logic [NBE-1:0]  a_port_BE,
    input  logic [ADDR-1:0] a_port_ADDR,
    input  logic [DATA-1:0] a_port_data_IN,
    output logic [DATA-1:0] a_port_data_OUT,
    output logic            a_port_VLD,
    input  logic            b_port_EN,
    input  logic            b_port_WR,
    input  logic [NBE-1:0]  b_port_BE,
    input  logic [ADDR-1:0] b_port_ADDR,
    input  logic [DATA-1:0] b_port_data_IN,
    output logic [DATA-1:0] b_port_data_OUT,
    output logic            b_port_VLD,
    output logic            coll_FLAG
);

    localparam int DEPTH = 1 << ADDR;

    generate
        if ((DATA % BYTE) != 0) begin : g_bad_width
            $error("dpram_pipe: DATA must be a multiple of BYTE");
        end
    endgenerate

    logic [DATA-1:0] r_mem [DEPTH];

    logic            w_a_wr;
    logic            w_b_wr;
    logic            w_coll;
    logic [DATA-1:0] w_a_old;
    logic [DATA-1:0] w_b_old;
    logic [DATA-1:0] w_a_rd;
    logic [DATA-1:0] w_b_rd;

    logic [DATA-1:0] r_a_dout;
    logic [DATA-1:0] r_b_dout;
    logic            r_a_vld;
    logic            r_b_vld;
    logic            r_coll;

    function automatic logic [DATA-1:0] f_merge(input logic [DATA-1:0] old_w,
                                                input logic [DATA-1:0] new_w,
                                                input logic [NBE-1:0]  be);
        logic [DATA-1:0] res;
        res = old_w;
        for (int i = 0; i < NBE; i++) begin
            if (be[i]) begin
                res[i*BYTE +: BYTE] = new_w[i*BYTE +: BYTE];
            end else begin
                res[i*BYTE +: BYTE] = old_w[i*BYTE +: BYTE];
            end
        end
        return res;
    endfunction

    assign w_a_wr  = a_port_EN & a_port_WR;
    assign w_b_wr  = b_port_EN & b_port_WR;
    assign w_coll  = w_a_wr & w_b_wr & (a_port_ADDR == b_port_ADDR);
    assign w_a_old = r_mem[a_port_ADDR];
    assign w_b_old = r_mem[b_port_ADDR];

    // Read-data selection: cross-port reads always see the pre-edge word.
    always_comb begin
        w_a_rd = w_a_old;
        w_b_rd = w_b_old;
        if ((RDW_MODE == 1) && w_a_wr) begin
            w_a_rd = f_merge(w_a_old, a_port_data_IN, a_port_BE);
        end else begin
            w_a_rd = w_a_old;
        end
        if ((RDW_MODE == 1) && w_b_wr) begin
            w_b_rd = f_merge(w_b_old, b_port_data_IN, b_port_BE);
        end else begin
            w_b_rd = w_b_old;
        end
    end

    // Memory array writes; port A is applied last so it wins shared lanes on a collision.
    always_ff @(posedge clK) begin
        if (rst_N) begin
            for (int i = 0; i < NBE; i++) begin
                if (w_b_wr && b_port_BE[i]) begin
                    r_mem[b_port_ADDR][i*BYTE +: BYTE] <= b_port_data_IN[i*BYTE +: BYTE];
                end
                if (w_a_wr && a_port_BE[i]) begin
                    r_mem[a_port_ADDR][i*BYTE +: BYTE] <= a_port_data_IN[i*BYTE +: BYTE];
                end
            end
        end
    end

    // First read stage: data holds while the port is idle.
    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            r_a_dout <= {DATA{1'b0}};
            r_b_dout <= {DATA{1'b0}};
            r_a_vld  <= 1'b0;
            r_b_vld  <= 1'b0;
            r_coll   <= 1'b0;
        end else begin
            r_a_vld <= a_port_EN;
            r_b_vld <= b_port_EN;
            r_coll  <= w_coll;
            if (a_port_EN) begin
                r_a_dout <= w_a_rd;
            end
            if (b_port_EN) begin
                r_b_dout <= w_b_rd;
            end
        end
    end

`ifdef DPRAM_PIPE_OREG_EN
    logic [DATA-1:0] r_a_dout2;
    logic [DATA-1:0] r_b_dout2;
    logic            r_a_vld2;
    logic            r_b_vld2;
    logic            r_coll2;

    // Optional output stage; loads only when the first stage carries a result.
    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            r_a_dout2 <= {DATA{1'b0}};
            r_b_dout2 <= {DATA{1'b0}};
            r_a_vld2  <= 1'b0;
            r_b_vld2  <= 1'b0;
            r_coll2   <= 1'b0;
        end else begin
            r_a_vld2 <= r_a_vld;
            r_b_vld2 <= r_b_vld;
            r_coll2  <= r_coll;
            if (r_a_vld) begin
                r_a_dout2 <= r_a_dout;
            end
            if (r_b_vld) begin
                r_b_dout2 <= r_b_dout;
            end
        end
    end

    assign a_port_data_OUT = r_a_dout2;
    assign b_port_data_OUT = r_b_dout2;
    assign a_port_VLD      = r_a_vld2;
    assign b_port_VLD      = r_b_vld2;
    assign coll_FLAG       = r_coll2;
`else
    assign a_port_data_OUT = r_a_dout;
    assign b_port_data_OUT = r_b_dout;
    assign a_port_VLD      = r_a_vld;
    assign b_port_VLD      = r_b_vld;
    assign coll_FLAG       = r_coll;
`endif

endmodule

// File: tb/tb_dpram_pipe.sv
// Directed scoreboard bench for dpram_pipe: one read-first and one write-first instance driven in parallel.
module tb_dpram_pipe;

    typedef struct {
        logic [31:0] data;
        logic        chk;
        logic        coll;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_en, a_wr, b_en, b_wr;
    logic [3:0]  a_be, b_be, a_addr, b_addr;
    logic [31:0] a_din, b_din;

    logic [31:0] a_out0, b_out0, a_out1, b_out1;
    logic        a_vld0, b_vld0, a_vld1, b_vld1, coll0, coll1;

    logic [31:0] dout [4];
    logic        vld  [4];
    logic        coll [2];

    item_t       q [4][$];
    logic [31:0] mdl [16];
    logic [31:0] last_exp [4];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          coll_cnt [2];
    int          b_run = 0;
    int          b_max = 0;

    always #5 clk = ~clk;

    dpram_pipe #(.DATA(32), .ADDR(4), .BYTE(8), .RDW_MODE(0)) u_dut0 (
        .clK(clk), .rst_N(rst_n),
        .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
        .a_port_data_IN(a_din), .a_port_data_OUT(a_out0), .a_port_VLD(a_vld0),
        .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
        .b_port_data_IN(b_din), .b_port_data_OUT(b_out0), .b_port_VLD(b_vld0),
        .coll_FLAG(coll0)
    );

    dpram_pipe #(.DATA(32), .ADDR(4), .BYTE(8), .RDW_MODE(1)) u_dut1 (
        .clK(clk), .rst_N(rst_n),
        .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_addr),
        .a_port_data_IN(a_din), .a_port_data_OUT(a_out1), .a_port_VLD(a_vld1),
        .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_addr),
        .b_port_data_IN(b_din), .b_port_data_OUT(b_out1), .b_port_VLD(b_vld1),
        .coll_FLAG(coll1)
    );

    assign dout[0] = a_out0;
    assign dout[1] = b_out0;
    assign dout[2] = a_out1;
    assign dout[3] = b_out1;
    assign vld[0]  = a_vld0;
    assign vld[1]  = b_vld0;
    assign vld[2]  = a_vld1;
    assign vld[3]  = b_vld1;
    assign coll[0] = coll0;
    assign coll[1] = coll1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [31:0] d, input logic chk, input logic c);
        item_t it;
        it.data = d;
        it.chk  = chk;
        it.coll = c;
        q[p].push_back(it);
        if (chk) last_exp[p] = d;
    endtask

    task automatic set_a(input logic en, input logic wr, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] din);
        a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
    endtask

    task automatic set_b(input logic en, input logic wr, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] din);
        b_en = en; b_wr = wr; b_be = be; b_addr = addr; b_din = din;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        set_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("%s_dout%0d", tag, p), dout[p], 32'h0);
            check($sformatf("%s_vld%0d", tag, p), {31'd0, vld[p]}, 32'd0);
        end
        check($sformatf("%s_coll0", tag), {31'd0, coll[0]}, 32'd0);
        check($sformatf("%s_coll1", tag), {31'd0, coll[1]}, 32'd0);
    endtask

    // Output monitor: pops one expected result per valid strobe, away from the active edge.
    always @(negedge clk) begin
        item_t it;
        if (rst_n) begin
            for (int p = 0; p < 4; p++) begin
                if (vld[p]) begin
                    check($sformatf("vld_has_request%0d", p), 32'(q[p].size() > 0), 32'd1);
                    if (q[p].size() > 0) begin
                        it = q[p].pop_front();
                        if (it.chk) check($sformatf("rdata%0d", p), dout[p], it.data);
                        if ((p % 2) == 0) check($sformatf("coll_align%0d", p / 2),
                                                {31'd0, coll[p / 2]}, {31'd0, it.coll});
                    end
                end
            end
            if (coll[0]) coll_cnt[0]++;
            if (coll[1]) coll_cnt[1]++;
            if (vld[1]) b_run++;
            else b_run = 0;
            if (b_run > b_max) b_max = b_run;
        end
    end

    function automatic logic [31:0] init_val(input int i);
        if (i == 5) return 32'h1122_3344;
        else if (i == 7) return 32'h0000_0000;
        else return 32'h1000_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    initial begin
        coll_cnt[0] = 0;
        coll_cnt[1] = 0;
        rst_n = 1'b0;
        idle();
        repeat (3) cyc();
        check_reset_state("reset");
        rst_n = 1'b1;

        // Fill memory through port A; read-first data is undefined here.
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b1, 4'hF, 4'(i), init_val(i));
            push(0, 32'h0, 1'b0, 1'b0);
            push(2, init_val(i), 1'b1, 1'b0);
            mdl[i] = init_val(i);
            cyc();
        end

        // Full-word write then cross-port read next cycle.
        set_a(1'b1, 1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF);
        push(0, mdl[3], 1'b1, 1'b0);
        push(2, 32'hDEAD_BEEF, 1'b1, 1'b0);
        mdl[3] = 32'hDEAD_BEEF;
        cyc();
        idle();
        set_b(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
        push(1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        push(3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc();
        idle();
        cyc();

        // Partial lane write.
        set_a(1'b1, 1'b1, 4'h5, 4'd5, 32'hAABB_CCDD);
        push(0, 32'h1122_3344, 1'b1, 1'b0);
        push(2, 32'h11BB_33DD, 1'b1, 1'b0);
        mdl[5] = 32'h11BB_33DD;
        cyc();
        set_a(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        push(0, 32'h11BB_33DD, 1'b1, 1'b0);
        push(2, 32'h11BB_33DD, 1'b1, 1'b0);
        cyc();

        // Read-during-write on both ports at addr 7.
        set_a(1'b1, 1'b1, 4'hF, 4'd7, 32'h1234_5678);
        set_b(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        push(0, 32'h0000_0000, 1'b1, 1'b0);
        push(2, 32'h1234_5678, 1'b1, 1'b0);
        push(1, 32'h0000_0000, 1'b1, 1'b0);
        push(3, 32'h0000_0000, 1'b1, 1'b0);
        mdl[7] = 32'h1234_5678;
        cyc();
        idle();
        set_a(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        push(0, 32'h1234_5678, 1'b1, 1'b0);
        push(2, 32'h1234_5678, 1'b1, 1'b0);
        cyc();

        // Write/write collision at addr 9.
        set_a(1'b1, 1'b1, 4'h3, 4'd9, 32'hAAAA_AAAA);
        set_b(1'b1, 1'b1, 4'hF, 4'd9, 32'hBBBB_BBBB);
        push(0, mdl[9], 1'b1, 1'b1);
        push(2, {mdl[9][31:16], 16'hAAAA}, 1'b1, 1'b1);
        push(1, mdl[9], 1'b1, 1'b0);
        push(3, 32'hBBBB_BBBB, 1'b1, 1'b0);
        mdl[9] = 32'hBBBB_AAAA;
        cyc();
        set_a(1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        set_b(1'b1, 1'b0, 4'h0, 4'd9, 32'h0);
        for (int p = 0; p < 4; p++) push(p, 32'hBBBB_AAAA, 1'b1, 1'b0);
        cyc();
        idle();

        // Zero byte-enable write: no change, still a valid read.
        set_a(1'b1, 1'b1, 4'h0, 4'd4, 32'hFFFF_FFFF);
        push(0, mdl[4], 1'b1, 1'b0);
        push(2, mdl[4], 1'b1, 1'b0);
        cyc();
        set_a(1'b1, 1'b0, 4'h0, 4'd4, 32'h0);
        push(0, mdl[4], 1'b1, 1'b0);
        push(2, mdl[4], 1'b1, 1'b0);
        cyc();
        idle();
        repeat (3) cyc();
        for (int p = 0; p < 4; p++) check($sformatf("hold%0d", p), dout[p], last_exp[p]);

        // Streaming reads on port B.
        for (int i = 0; i < 16; i++) begin
            set_b(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            push(1, mdl[i], 1'b1, 1'b0);
            push(3, mdl[i], 1'b1, 1'b0);
            cyc();
        end
        idle();
        repeat (3) cyc();
        check("stream_run", 32'(b_max), 32'd16);

        // Reset mid-stream with a write pending.
        for (int i = 0; i < 3; i++) begin
            set_b(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            push(1, mdl[i], 1'b1, 1'b0);
            push(3, mdl[i], 1'b1, 1'b0);
            cyc();
        end
        set_a(1'b1, 1'b1, 4'hF, 4'd2, 32'h5555_5555);
        set_b(1'b1, 1'b0, 4'h0, 4'd4, 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        for (int p = 0; p < 4; p++) q[p].delete();
        cyc();
        check_reset_state("inrst");
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
        set_b(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
        push(0, mdl[2], 1'b1, 1'b0);
        push(2, mdl[2], 1'b1, 1'b0);
        push(1, mdl[1], 1'b1, 1'b0);
        push(3, mdl[1], 1'b1, 1'b0);
        cyc();
        idle();
        repeat (4) cyc();

        for (int p = 0; p < 4; p++) check($sformatf("drained%0d", p), 32'(q[p].size()), 32'd0);
        check("coll_pulses0", 32'(coll_cnt[0]), 32'd1);
        check("coll_pulses1", 32'(coll_cnt[1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
